mult_share_arb: RTL

- Shares one registered W x W multiplier between two requesters.
- Each requester presents operands and a signed/unsigned select on a req/gnt handshake. A round-robin arbiter picks one request per cycle.
- The product is registered and offered downstream on a valid/ready port, tagged with the requester id.
- Sits between the operand-producing units and the single multiplier resource in the arithmetic datapath.

---
 rtl/mult_share_arb_if.sv | 39 +++
 rtl/mult_share_arb.sv | 72 +++++++
 2 files changed

// File: rtl/mult_share_arb_if.sv
// Requester / downstream bundle for mult_share_arb.
// MULT_SHARE_ARB_PRIO_EN adds the prio0 override input.
interface mult_share_arb_if #(parameter int W = 4);
  logic           req0;
  logic [W-1:0]   a0;
  logic [W-1:0]   b0;
  logic           sgn0;
  logic           gnt0;
  logic           req1;
  logic [W-1:0]   a1;
  logic [W-1:0]   b1;
  logic           sgn1;
  logic           gnt1;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
  logic           out_id;
`ifdef MULT_SHARE_ARB_PRIO_EN
  logic           prio0;

  modport master (
    output req0, a0, b0, sgn0, req1, a1, b1, sgn1, out_ready, prio0,
    input  gnt0, gnt1, out_valid, out_p, out_id
  );
  modport slave (
    input  req0, a0, b0, sgn0, req1, a1, b1, sgn1, out_ready, prio0,
    output gnt0, gnt1, out_valid, out_p, out_id
  );
`else
  modport master (
    output req0, a0, b0, sgn0, req1, a1, b1, sgn1, out_ready,
    input  gnt0, gnt1, out_valid, out_p, out_id
  );
  modport slave (
    input  req0, a0, b0, sgn0, req1, a1, b1, sgn1, out_ready,
    output gnt0, gnt1, out_valid, out_p, out_id
  );
`endif
endinterface

// File: rtl/mult_share_arb.sv
// Round-robin shared W x W registered multiplier for two requesters.
// Optional MULT_SHARE_ARB_PRIO_EN: prio0 lets requester 0 win every arbitration.
module mult_share_arb #(
  parameter int W = 4
) (
  input logic             clk,
  input logic             rst_n,
  mult_share_arb_if.slave bus
);
  typedef enum logic {IDLE, HOLD} state_t;

  state_t         r_state;
  logic           r_last;
  logic [2*W-1:0] r_p;
  logic           r_id;

  logic           w_can;
  logic           w_prio0;
  logic           w_sel1;
  logic           w_gnt0;
  logic           w_gnt1;
  logic [W-1:0]   w_a;
  logic [W-1:0]   w_b;
  logic           w_s;
  logic [2*W-1:0] w_ax;
  logic [2*W-1:0] w_bx;
  logic [2*W-1:0] w_prod;

`ifdef MULT_SHARE_ARB_PRIO_EN
  assign w_prio0 = bus.prio0;
`else
  assign w_prio0 = 1'b0;
`endif

  assign w_can = (r_state == IDLE) || bus.out_ready;

  // Requester 1 wins when alone, or when both ask and 0 was served last (unless prio0 forces 0).
  assign w_sel1 = bus.req1 & (~bus.req0 | (~w_prio0 & ~r_last));
  assign w_gnt0 = rst_n & w_can & bus.req0 & ~w_sel1;
  assign w_gnt1 = rst_n & w_can & w_sel1;

  assign w_a = w_sel1 ? bus.a1   : bus.a0;
  assign w_b = w_sel1 ? bus.b1   : bus.b0;
  assign w_s = w_sel1 ? bus.sgn1 : bus.sgn0;

  // Low 2W bits of the extended product are exact for both signed and unsigned.
  assign w_ax   = w_s ? {{W{w_a[W-1]}}, w_a} : {{W{1'b0}}, w_a};
  assign w_bx   = w_s ? {{W{w_b[W-1]}}, w_b} : {{W{1'b0}}, w_b};
  assign w_prod = w_ax * w_bx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_p     <= '0;
      r_id    <= 1'b0;
    end else if (w_gnt0 || w_gnt1) begin
      r_state <= HOLD;
      r_last  <= w_gnt1;
      r_p     <= w_prod;
      r_id    <= w_gnt1;
    end else if (r_state == HOLD && bus.out_ready) begin
      r_state <= IDLE;
    end
  end

  assign bus.gnt0      = w_gnt0;
  assign bus.gnt1      = w_gnt1;
  assign bus.out_valid = (r_state == HOLD);
  assign bus.out_p     = r_p;
  assign bus.out_id    = r_id;
endmodule
